// File: rtl/booth_pkg.sv
// Shared types and encodings for the radix-2 Booth multiplier controller and datapath.
package booth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EVAL,
    SHIFT,
    DONE
  } state_t;

  // {Q0, Q-1} pairs that request an add or a subtract of M.
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  localparam logic ADDSUB_ADD = 1'b1;
  localparam logic ADDSUB_SUB = 1'b0;

endpackage

// File: rtl/booth_seq_ctrl.sv
// Sequencing controller for the radix-2 Booth shift-add datapath: accepts an operand
// pair, clears/loads the datapath, runs N evaluate/shift steps, then presents the product.
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product_o,
  output logic           ovf_o,
  output logic           dp_rst,
  output logic [N-1:0]   dp_a,
  output logic [N-1:0]   dp_b,
  output logic           dp_load_a,
  output logic           dp_load_b,
  output logic           dp_load_add,
  output logic           dp_add_sub,
  output logic           dp_shift,
  input  logic [1:0]     dp_q_lsb,
  input  logic [2*N-1:0] dp_y,
  output state_t         dbg_state_o
);

  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0] A_MIN = {1'b1, {(N-1){1'b0}}};

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready only in IDLE; out_valid only in DONE, held with the product until out_ready.

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic          accept;
  logic          last_shift;
  logic          eval_act;

  assign accept     = (state_q == IDLE) && in_valid && !rst;
  assign last_shift = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (in_valid) state_q <= LOAD;
        LOAD:    state_q <= EVAL;
        EVAL:    state_q <= SHIFT;
        SHIFT:   state_q <= last_shift ? DONE : EVAL;
        DONE:    if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      a_q   <= a_i;
      b_q   <= b_i;
      cnt_q <= '0;
    end else if (state_q == SHIFT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // The clear pulse rides on the accept edge so the datapath starts from zero in LOAD.
  assign dp_rst = rst || accept;

  assign eval_act    = !rst && (state_q == EVAL);
  assign dp_load_add = eval_act && ((dp_q_lsb == BOOTH_ADD) || (dp_q_lsb == BOOTH_SUB));
  assign dp_add_sub  = (eval_act && (dp_q_lsb == BOOTH_ADD)) ? ADDSUB_ADD : ADDSUB_SUB;
  assign dp_load_a   = !rst && (state_q == LOAD);
  assign dp_load_b   = !rst && (state_q == LOAD);
  assign dp_shift    = !rst && (state_q == SHIFT);

  assign in_ready  = !rst && (state_q == IDLE);
  assign out_valid = !rst && (state_q == DONE);
  // The most negative multiplicand overflows the N-bit HQ on HQ-M.
  assign ovf_o     = out_valid && (a_q == A_MIN);
  assign product_o = dp_y;

  assign dp_a        = a_q;
  assign dp_b        = b_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Bench for booth_seq_ctrl: drives it against a behavioural Booth datapath and checks
// products against plain signed multiplication.
module tb_booth_seq_ctrl;
  import booth_pkg::*;

  localparam int N  = 4;
  localparam int PW = 2 * N;
  localparam logic [N-1:0] A_MIN = {1'b1, {(N-1){1'b0}}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  a_i = '0;
  logic [N-1:0]  b_i = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [PW-1:0] product_o;
  logic          ovf_o;
  logic          dp_rst;
  logic [N-1:0]  dp_a;
  logic [N-1:0]  dp_b;
  logic          dp_load_a;
  logic          dp_load_b;
  logic          dp_load_add;
  logic          dp_add_sub;
  logic          dp_shift;
  logic [1:0]    dp_q_lsb;
  logic [PW-1:0] dp_y;
  state_t        dbg_state;

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q[$];

  always #5 clk = ~clk;

  booth_seq_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a_i(a_i), .b_i(b_i),
    .out_valid(out_valid), .out_ready(out_ready), .product_o(product_o), .ovf_o(ovf_o),
    .dp_rst(dp_rst), .dp_a(dp_a), .dp_b(dp_b),
    .dp_load_a(dp_load_a), .dp_load_b(dp_load_b), .dp_load_add(dp_load_add),
    .dp_add_sub(dp_add_sub), .dp_shift(dp_shift), .dp_q_lsb(dp_q_lsb), .dp_y(dp_y),
    .dbg_state_o(dbg_state)
  );

  // Behavioural HQ/LQ/Q-1/M datapath reacting to the controller's strobes.
  logic [N-1:0] hq, lq, m;
  logic         qm1;
  always @(posedge clk) begin
    if (dp_rst) begin
      hq <= '0; lq <= '0; qm1 <= 1'b0; m <= '0;
    end else begin
      if (dp_load_a) m <= dp_a;
      if (dp_load_b) lq <= dp_b;
      if (dp_load_add) hq <= dp_add_sub ? hq + m : hq - m;
      if (dp_shift) {hq, lq, qm1} <= {hq[N-1], hq, lq};
    end
  end
  assign dp_q_lsb = {lq[0], qm1};
  assign dp_y     = {hq, lq};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe-exclusivity monitor over every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      assert (!(dp_shift && (dp_load_a || dp_load_b || dp_load_add))) else begin
        errors++;
        $error("FAIL excl: shift=%0b la=%0b lb=%0b ladd=%0b", dp_shift, dp_load_a, dp_load_b, dp_load_add);
      end
      assert (!dp_load_add || dbg_state == EVAL) else begin
        errors++;
        $error("FAIL load_add_state: observed state %0d expected EVAL", dbg_state);
      end
    end
  end

  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input int stall);
    int lat;
    int shifts;
    int ia;
    int ib;
    logic [PW-1:0] exp;
    logic [PW-1:0] held;
    logic exp_ovf;
    ia = $signed(a);
    ib = $signed(b);
    exp_q.push_back(PW'(ia * ib));
    exp_ovf = (a == A_MIN);
    lat = 0;
    while (!in_ready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("ready_before_accept", in_ready, 1);
    a_i = a; b_i = b; in_valid = 1'b1; out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1; shifts = 0;
    while (!out_valid && lat < 100) begin
      if (dp_shift) shifts++;
      @(negedge clk);
      lat++;
    end
    exp = exp_q.pop_front();
    check("latency", lat, 2 * N + 2);
    check("shift_count", shifts, N);
    check("ovf", ovf_o, exp_ovf);
    if (!exp_ovf) check("product", product_o, exp);
    if (stall > 0) begin
      held = product_o;
      in_valid = 1'b1; a_i = ~a; b_i = ~b;
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        check("stall_valid", out_valid, 1);
        check("stall_product", product_o, held);
        check("stall_ovf", ovf_o, exp_ovf);
        check("stall_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      in_valid = 1'b0;
    end
    @(negedge clk);
    check("idle_after_done", in_ready, 1);
    check("valid_drop", out_valid, 0);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_dp_rst", dp_rst, 1);
    check("rst_strobes", {dp_load_a, dp_load_b, dp_load_add, dp_shift, dp_add_sub}, 0);
    check("rst_dp_ab", {dp_a, dp_b}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1);
    check("dp_rst_released", dp_rst, 0);

    // Directed operand pairs.
    do_op(4'd3, 4'd5, 0);
    do_op(4'hD, 4'd5, 0);
    do_op(4'd7, 4'h8, 0);
    do_op(4'h9, 4'h9, 0);
    do_op(4'd0, 4'hF, 0);
    do_op(4'h8, 4'd3, 0);
    do_op(4'h3, 4'h8, 0);

    // Consumer stall, then back-to-back accept.
    do_op(4'd6, 4'hB, 5);
    do_op(4'd2, 4'd7, 0);

    // Reset during EVAL_2 discards the operation.
    a_i = 4'd5; b_i = 4'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("at_eval2", dbg_state, EVAL);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_state", dbg_state, IDLE);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_dp_rst", dp_rst, 1);
    check("mid_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", in_ready, 1);
    do_op(4'd2, 4'd2, 0);

    // Randomised operands.
    for (int t = 0; t < 24; t++) begin
      do_op(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0) ? 2 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_seq_ctrl.md
# booth_seq_ctrl

Sequencing controller for the radix-2 Booth shift-add multiplier datapath (HQ/LQ/Q-1 shift register, M register, adder/subtractor). It accepts signed operand pairs over a valid/ready handshake and latches them. It clears and loads the datapath, then runs N evaluate/shift iterations driven by the datapath's {Q0,Q-1} feedback. It presents the 2N-bit product over a second valid/ready handshake. A top-level wrapper instantiates this block and the datapath side by side.

## Interface
Parameters:
- N, 4, operand width in bits (N ≥ 2); product is 2N bits.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  controller idle and able to accept.
- a_i  in  N  signed multiplicand.
- b_i  in  N  signed multiplier.
- out_valid  out  1  product available.
- out_ready  in  1  consumer takes product.
- product_o  out  2N  signed product; pass-through of datapath Y.
- ovf_o  out  1  unsupported-operand flag, qualified by out_valid.
- dp_rst  out  1  datapath reset, equal to rst OR clear pulse.
- dp_a  out  N  latched multiplicand, driven to datapath A.
- dp_b  out  N  latched multiplier, driven to datapath B.
- dp_load_a  out  1  datapath load_A.
- dp_load_b  out  1  datapath load_B.
- dp_load_add  out  1  datapath load_add.
- dp_add_sub  out  1  datapath add_sub: 1 = HQ+M, 0 = HQ−M.
- dp_shift  out  1  datapath arithmetic-shift enable.
- dp_q_lsb  in  2  datapath {Q0, Q-1}.
- dp_y  in  2N  datapath product {HQ, LQ}.

## Operation
- States: IDLE, LOAD, EVAL, SHIFT, DONE. Iteration counter cnt is $clog2(N+1) bits.
- IDLE: in_ready=1.
  - On in_valid, the pair is accepted. a_q/b_q capture a_i/b_i, cnt is cleared, and dp_rst=1 combinationally (Mealy) in that cycle, so HQ, LQ, Q-1 and M are zeroed at the edge.
  - Next state is LOAD.
- LOAD: dp_load_a=dp_load_b=1 → EVAL.
- EVAL: decode dp_q_lsb.
  - 01: dp_load_add=1, dp_add_sub=1.
  - 10: dp_load_add=1, dp_add_sub=0.
  - 00 or 11: no strobe.
  - Next state is SHIFT.
- SHIFT: dp_shift=1, cnt+1.
  - If cnt == N−1 → DONE, else → EVAL.
- DONE: out_valid=1, product_o=dp_y.
  - On out_ready → IDLE.
  - The datapath receives no strobes in DONE or IDLE, so dp_y holds.
- Exclusivity:
  - dp_shift is never asserted together with dp_load_add, dp_load_a or dp_load_b.
  - dp_load_add is never asserted outside EVAL.
- ovf_o is set when a_q == −2^(N−1), because the N-bit HQ overflows on HQ−M. It is asserted throughout DONE, and the product value is undefined in that case. b = −2^(N−1) is fully supported.
- dp_a/dp_b are driven from a_q/b_q, which hold until the next accept.
- Reset, including mid-operation:
  - Values: state=IDLE, cnt=0, a_q=b_q=0, dp_rst=1, all strobes 0, out_valid=0, ovf_o=0.
  - The operation in flight is discarded, and no product is emitted for it.

## Timing
- Accept at edge k: LOAD in cycle k+1; EVAL_i in cycle k+2i; SHIFT_i in cycle k+2i+1 (i=1..N); DONE from cycle k+2N+2.
- Latency: in_valid accept to out_valid = 2N+2 cycles.
- Minimum period with out_ready tied high: 2N+3 cycles per operation.
- in_valid is ignored outside IDLE.
- out_valid, product_o and ovf_o are stable while out_ready=0.
- Inputs and outputs during DONE:
  - dp_q_lsb is ignored outside EVAL.
  - product_o is driven continuously but is meaningful only while out_valid=1.
- Reset values of outputs:
  - in_ready=0 while rst=1, and 1 in the first cycle after reset release.
  - out_valid=0, ovf_o=0, all dp strobes 0, dp_a=dp_b=0, dp_rst=1.

## Structure
- Shared package booth_pkg:
  - State enum state_t {IDLE, LOAD, EVAL, SHIFT, DONE}.
  - Booth pair constants: BOOTH_ADD=2'b01, BOOTH_SUB=2'b10.
  - add_sub encodings: ADDSUB_ADD=1, ADDSUB_SUB=0.
- Single module with three parts: state register, next-state/Moore output logic, and operand/counter registers.
- No sub-module. The top wrapper booth_mult_top connects this block to the datapath.

## Test plan
- N=4, a=3, b=5, out_ready=1 → out_valid exactly 10 cycles after accept; product 0x0F; ovf_o=0.
- a=−3, b=5 → 0xF1. a=7, b=−8 → 0xC8. a=−7, b=−7 → 0x31. a=0, b=−1 → 0x00.
- a=−8, b=3 → ovf_o=1 with out_valid.
- out_ready held low 5 cycles in DONE → product_o and out_valid stable, in_ready=0, and in_valid ignored. Raise out_ready → IDLE next cycle, then back-to-back accept.
- rst pulsed during EVAL_2 → next cycle IDLE, out_valid=0, dp_rst=1. A new operation 2×2 then completes with product 0x04.
- Assertion checks throughout all runs:
  - dp_shift never asserted together with any load strobe.
  - dp_load_add asserted only in EVAL.
  - Exactly N dp_shift pulses per operation.
